// File: rtl/rl_ingress_gate.sv
// Ingress gate ahead of the per-client rate limiter: buffers descriptors, issues
// client IDs, pairs verdicts with descriptors. Define RL_GATE_DROP_FWD_EN to forward drops.
module rl_ingress_gate #(
  parameter int CLIENT_W   = 10,
  parameter int DESC_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CLIENT_W-1:0]         in_client_id,
  input  logic [DESC_W-1:0]           in_desc,
  output logic                        lim_pkt_valid,
  output logic [CLIENT_W-1:0]         lim_client_id,
  input  logic                        lim_accept,
  input  logic                        lim_drop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CLIENT_W-1:0]         out_client_id,
  output logic [DESC_W-1:0]           out_desc,
  output logic                        out_dropped,
  output logic [CNT_W-1:0]            accept_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic                        err_protocol,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [CLIENT_W-1:0] fifo_cid_q  [FIFO_DEPTH];
  logic [DESC_W-1:0]   fifo_desc_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic                in_ready_q, in_ready_d;
  logic                inflight_q, inflight_d;
  logic [CLIENT_W-1:0] inf_cid_q, inf_cid_d;
  logic [DESC_W-1:0]   inf_desc_q, inf_desc_d;
  logic [CLIENT_W-1:0] ob_cid_q  [2];
  logic [DESC_W-1:0]   ob_desc_q [2];
  logic                ob_wr_q, ob_wr_d, ob_rd_q, ob_rd_d;
  logic [1:0]          ob_occ_q, ob_occ_d;
  logic [CNT_W-1:0]    accept_cnt_q, accept_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                err_q, err_d;
`ifdef RL_GATE_DROP_FWD_EN
  logic                ob_drop_q [2];
`endif

  logic       push_s, fifo_empty_s, out_valid_s, out_pop_s, issue_s;
  logic [2:0] occ_eff_s;
  logic       verdict_acc_s, verdict_drop_s, malformed_s, ob_push_s;

  // Handshakes, issue credit and verdict decode
  always_comb begin
    push_s         = in_valid & in_ready_q;
    fifo_empty_s   = (level_q == {(AW+1){1'b0}});
    out_valid_s    = (ob_occ_q != 2'd0);
    out_pop_s      = out_valid_s & out_ready;
    // Credit counts the in-flight entry so the 2-deep output buffer never overflows
    occ_eff_s      = {1'b0, ob_occ_q} - {2'b00, out_pop_s} + {2'b00, inflight_q};
    issue_s        = ~fifo_empty_s & (occ_eff_s < 3'd2);
    verdict_acc_s  = inflight_q & lim_accept & ~lim_drop;
    verdict_drop_s = inflight_q & ~verdict_acc_s;
    malformed_s    = inflight_q & (lim_accept == lim_drop);
`ifdef RL_GATE_DROP_FWD_EN
    ob_push_s      = inflight_q;
`else
    ob_push_s      = verdict_acc_s;
`endif
  end

  // Next-state for pointers, occupancy, in-flight slot and statistics
  always_comb begin
    wr_ptr_d   = push_s  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = issue_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + (AW+1)'(push_s) - (AW+1)'(issue_s);
    in_ready_d = (level_d != FULL_LVL);
    inflight_d = issue_s;
    inf_cid_d  = issue_s ? fifo_cid_q[rd_ptr_q]  : inf_cid_q;
    inf_desc_d = issue_s ? fifo_desc_q[rd_ptr_q] : inf_desc_q;
    ob_occ_d   = ob_occ_q + 2'(ob_push_s) - 2'(out_pop_s);
    ob_wr_d    = ob_wr_q ^ ob_push_s;
    ob_rd_d    = ob_rd_q ^ out_pop_s;
    if (verdict_acc_s && (accept_cnt_q != {CNT_W{1'b1}})) begin
      accept_cnt_d = accept_cnt_q + CNT_W'(1);
    end else begin
      accept_cnt_d = accept_cnt_q;
    end
    if (verdict_drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    err_d = err_q | malformed_s;
  end

  // Control and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      level_q      <= {(AW+1){1'b0}};
      in_ready_q   <= 1'b0;
      inflight_q   <= 1'b0;
      inf_cid_q    <= {CLIENT_W{1'b0}};
      inf_desc_q   <= {DESC_W{1'b0}};
      ob_wr_q      <= 1'b0;
      ob_rd_q      <= 1'b0;
      ob_occ_q     <= 2'd0;
      accept_cnt_q <= {CNT_W{1'b0}};
      drop_cnt_q   <= {CNT_W{1'b0}};
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      in_ready_q   <= in_ready_d;
      inflight_q   <= inflight_d;
      inf_cid_q    <= inf_cid_d;
      inf_desc_q   <= inf_desc_d;
      ob_wr_q      <= ob_wr_d;
      ob_rd_q      <= ob_rd_d;
      ob_occ_q     <= ob_occ_d;
      accept_cnt_q <= accept_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      err_q        <= err_d;
    end
  end

  // Input FIFO storage; contents are qualified by level so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_cid_q[wr_ptr_q]  <= in_client_id;
      fifo_desc_q[wr_ptr_q] <= in_desc;
    end
  end

  // Output buffer storage, cleared so outputs read zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ob_cid_q[i]  <= {CLIENT_W{1'b0}};
        ob_desc_q[i] <= {DESC_W{1'b0}};
`ifdef RL_GATE_DROP_FWD_EN
        ob_drop_q[i] <= 1'b0;
`endif
      end
    end else if (ob_push_s) begin
      ob_cid_q[ob_wr_q]  <= inf_cid_q;
      ob_desc_q[ob_wr_q] <= inf_desc_q;
`ifdef RL_GATE_DROP_FWD_EN
      ob_drop_q[ob_wr_q] <= verdict_drop_s;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign lim_pkt_valid = issue_s;
  assign lim_client_id = fifo_empty_s ? {CLIENT_W{1'b0}} : fifo_cid_q[rd_ptr_q];
  assign out_valid     = out_valid_s;
  assign out_client_id = ob_cid_q[ob_rd_q];
  assign out_desc      = ob_desc_q[ob_rd_q];
`ifdef RL_GATE_DROP_FWD_EN
  assign out_dropped   = out_valid_s & ob_drop_q[ob_rd_q];
`else
  assign out_dropped   = 1'b0;
`endif
  assign accept_cnt    = accept_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign err_protocol  = err_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_rl_ingress_gate.sv
// Directed self-checking bench for rl_ingress_gate with a scripted limiter verdict queue.
module tb_rl_ingress_gate;
  localparam int CLIENT_W = 10;
  localparam int DESC_W   = 32;
  localparam int FDEPTH   = 16;
  localparam int CNT_W    = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0, in_ready;
  logic [CLIENT_W-1:0] in_client_id = '0;
  logic [DESC_W-1:0]   in_desc = '0;
  logic                lim_pkt_valid;
  logic [CLIENT_W-1:0] lim_client_id;
  logic                lim_accept = 1'b0, lim_drop = 1'b0;
  logic                out_valid, out_ready = 1'b0, out_dropped, err_protocol;
  logic [CLIENT_W-1:0] out_client_id;
  logic [DESC_W-1:0]   out_desc;
  logic [CNT_W-1:0]    accept_cnt, drop_cnt;
  logic [4:0]          fifo_level;

  always #5 clk = ~clk;

  rl_ingress_gate #(.CLIENT_W(CLIENT_W), .DESC_W(DESC_W), .FIFO_DEPTH(FDEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_client_id(in_client_id), .in_desc(in_desc),
    .lim_pkt_valid(lim_pkt_valid), .lim_client_id(lim_client_id),
    .lim_accept(lim_accept), .lim_drop(lim_drop),
    .out_valid(out_valid), .out_ready(out_ready), .out_client_id(out_client_id),
    .out_desc(out_desc), .out_dropped(out_dropped),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt), .err_protocol(err_protocol),
    .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0]          vq[$];   // {accept, drop} replies, one per issue
  logic                pend = 1'b0, stray = 1'b0;
  logic                last_lpv, last_ov, last_odrop, last_push;
  logic [CLIENT_W-1:0] last_lcid, last_ocid;
  logic [DESC_W-1:0]   last_odesc;
  int                  issue_cnt, rx_drop_cnt, run, max_run;
  logic [CLIENT_W-1:0] rx_cid[$];
  logic [DESC_W-1:0]   rx_desc[$];

  // One clock cycle: drive the limiter reply, sample, then advance to next negedge.
  task automatic cycle();
    logic [1:0] v;
    if (pend) v = (vq.size() > 0) ? vq.pop_front() : 2'b10;
    else v = 2'b00;
    if (stray) v = 2'b10;
    lim_accept = v[1];
    lim_drop   = v[0];
    #1;
    last_lpv   = lim_pkt_valid;
    last_lcid  = lim_client_id;
    last_ov    = out_valid;
    last_ocid  = out_client_id;
    last_odesc = out_desc;
    last_odrop = out_dropped;
    last_push  = in_valid & in_ready;
    if (lim_pkt_valid) begin
      issue_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (out_valid && out_ready) begin
      if (out_dropped) rx_drop_cnt++;
      else begin
        rx_cid.push_back(out_client_id);
        rx_desc.push_back(out_desc);
      end
    end
    pend = lim_pkt_valid;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_client_id = '0; in_desc = '0;
    out_ready = 1'b0; lim_accept = 1'b0; lim_drop = 1'b0;
    vq.delete(); rx_cid.delete(); rx_desc.delete();
    pend = 1'b0; stray = 1'b0;
    issue_cnt = 0; rx_drop_cnt = 0; run = 0; max_run = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, lim_pkt_valid, out_valid, out_dropped, err_protocol} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 00000", {in_ready, lim_pkt_valid, out_valid, out_dropped, err_protocol});
    end
    checks++;
    if ({accept_cnt, drop_cnt, fifo_level} !== {32'd0, 32'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_counts: acc=%0d drop=%0d lvl=%0d exp 0/0/0", accept_cnt, drop_cnt, fifo_level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    vq.push_back(2'b10);
    out_ready = 1'b1; in_valid = 1'b1; in_client_id = 10'd5; in_desc = 32'hA5A5_0001;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (last_lpv !== 1'b0) begin
      errors++; $display("FAIL basic_c0_issue: got %b exp 0", last_lpv);
    end
    cycle();
    checks++;
    if ({last_lpv, last_lcid} !== {1'b1, 10'd5}) begin
      errors++; $display("FAIL basic_c1_issue: lpv=%b cid=%0d exp 1/5", last_lpv, last_lcid);
    end
    cycle();
    checks++;
    if (last_ov !== 1'b0) begin
      errors++; $display("FAIL basic_c2_out: got %b exp 0", last_ov);
    end
    cycle();
    checks++;
    if ({last_ov, last_ocid, last_odesc, last_odrop} !== {1'b1, 10'd5, 32'hA5A5_0001, 1'b0}) begin
      errors++;
      $display("FAIL basic_c3_out: ov=%b cid=%0d desc=%h drop=%b exp 1/5/a5a50001/0", last_ov, last_ocid, last_odesc, last_odrop);
    end
    checks++;
    if ({accept_cnt, drop_cnt} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL basic_counts: acc=%0d drop=%0d exp 1/0", accept_cnt, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) vq.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_client_id = 10'(20 + i); in_desc = 32'hB000_0000 + 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (6) cycle();
    checks++;
    if (max_run !== 8 || issue_cnt !== 8) begin
      errors++; $display("FAIL b2b_issue_run: run=%0d issues=%0d exp 8/8", max_run, issue_cnt);
    end
    checks++;
    if (rx_cid.size() !== 4) begin
      errors++; $display("FAIL b2b_out_count: got %0d exp 4", rx_cid.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rx_cid[k] !== 10'(20 + 2*k) || rx_desc[k] !== 32'hB000_0000 + 32'(2*k)) begin
          errors++;
          $display("FAIL b2b_order[%0d]: cid=%0d desc=%h exp %0d/%h", k, rx_cid[k], rx_desc[k], 20 + 2*k, 32'hB000_0000 + 32'(2*k));
        end
      end
    end
    checks++;
    if ({accept_cnt, drop_cnt, err_protocol} !== {32'd4, 32'd4, 1'b0}) begin
      errors++; $display("FAIL b2b_counts: acc=%0d drop=%0d err=%b exp 4/4/0", accept_cnt, drop_cnt, err_protocol);
    end
    checks++;
`ifdef RL_GATE_DROP_FWD_EN
    if (rx_drop_cnt !== 4) begin
      errors++; $display("FAIL b2b_fwd_drops: got %0d exp 4", rx_drop_cnt);
    end
`else
    if (rx_drop_cnt !== 0) begin
      errors++; $display("FAIL b2b_out_dropped: got %0d exp 0", rx_drop_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    int pushed;
    apply_reset();
    pushed = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (pushed < 20); in_client_id = 10'(100 + pushed); in_desc = 32'hC000_0000 + 32'(pushed);
      cycle();
      if (last_push) pushed++;
    end
    checks++;
    if (pushed !== 18 || fifo_level !== 5'd16 || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_full: pushed=%0d lvl=%0d rdy=%b exp 18/16/0", pushed, fifo_level, in_ready);
    end
    checks++;
    if (issue_cnt !== 2 || last_lpv !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_issue: issues=%0d lpv=%b ov=%b exp 2/0/1", issue_cnt, last_lpv, out_valid);
    end
    checks++;
    if (lim_client_id !== 10'd102) begin
      errors++; $display("FAIL stall_head_cid: got %0d exp 102", lim_client_id);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 100 && rx_cid.size() < 20; c++) begin
      in_valid = (pushed < 20); in_client_id = 10'(100 + pushed); in_desc = 32'hC000_0000 + 32'(pushed);
      cycle();
      if (last_push) pushed++;
    end
    in_valid = 1'b0;
    checks++;
    if (rx_cid.size() !== 20) begin
      errors++; $display("FAIL stall_drain_count: got %0d exp 20 (cycle budget)", rx_cid.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (rx_cid[k] !== 10'(100 + k) || rx_desc[k] !== 32'hC000_0000 + 32'(k)) begin
          errors++; $display("FAIL stall_order[%0d]: cid=%0d desc=%h exp %0d", k, rx_cid[k], rx_desc[k], 100 + k);
        end
      end
    end
    checks++;
    if (accept_cnt !== 32'd20) begin
      errors++; $display("FAIL stall_acc: got %0d exp 20", accept_cnt);
    end
  endtask

  task automatic test_protocol_err();
    apply_reset();
    out_ready = 1'b1;
    vq.push_back(2'b11); vq.push_back(2'b00); vq.push_back(2'b10);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_client_id = 10'(30 + i); in_desc = 32'hE000_0000 + 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    checks++;
    if ({err_protocol, accept_cnt, drop_cnt} !== {1'b1, 32'd1, 32'd2}) begin
      errors++; $display("FAIL err_counts: err=%b acc=%0d drop=%0d exp 1/1/2", err_protocol, accept_cnt, drop_cnt);
    end
    checks++;
    if (rx_cid.size() !== 1 || rx_cid[0] !== 10'd32) begin
      errors++; $display("FAIL err_output: n=%0d exp 1 entry with cid 32", rx_cid.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_protocol !== 1'b0) begin
      errors++; $display("FAIL err_clear_on_reset: got %b exp 0", err_protocol);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_client_id = 10'(40 + i); in_desc = 32'hD000_0000 + 32'(i);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    checks++;
    if ({fifo_level, out_valid, accept_cnt} !== {5'd3, 1'b1, 32'd2} || pend !== 1'b1) begin
      errors++; $display("FAIL midop_state: lvl=%0d ov=%b acc=%0d inflight=%b exp 3/1/2/1", fifo_level, out_valid, accept_cnt, pend);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, lim_pkt_valid, out_valid, out_dropped, err_protocol, lim_client_id, out_client_id, out_desc} !== '0) begin
      errors++; $display("FAIL midop_reset_outs: rdy=%b lpv=%b ov=%b lcid=%0d ocid=%0d desc=%h exp all 0",
                         in_ready, lim_pkt_valid, out_valid, lim_client_id, out_client_id, out_desc);
    end
    checks++;
    if ({accept_cnt, drop_cnt, fifo_level} !== {32'd0, 32'd0, 5'd0}) begin
      errors++; $display("FAIL midop_reset_counts: acc=%0d drop=%0d lvl=%0d exp 0", accept_cnt, drop_cnt, fifo_level);
    end
    pend = 1'b0; vq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b1;
    cycle(); cycle();
    stray = 1'b0;
    repeat (2) cycle();
    checks++;
    if ({accept_cnt, drop_cnt, out_valid} !== {32'd0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL midop_stray_verdict: acc=%0d drop=%0d ov=%b exp 0/0/0", accept_cnt, drop_cnt, out_valid);
    end
  endtask

`ifdef RL_GATE_DROP_FWD_EN
  task automatic test_drop_fwd();
    apply_reset();
    out_ready = 1'b1;
    vq.push_back(2'b01);
    in_valid = 1'b1; in_client_id = 10'd7; in_desc = 32'h7777_0007;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({last_ov, last_odrop, last_ocid} !== {1'b1, 1'b1, 10'd7}) begin
      errors++; $display("FAIL fwd_out: ov=%b drop=%b cid=%0d exp 1/1/7", last_ov, last_odrop, last_ocid);
    end
    checks++;
    if ({accept_cnt, drop_cnt} !== {32'd0, 32'd1}) begin
      errors++; $display("FAIL fwd_counts: acc=%0d drop=%0d exp 0/1", accept_cnt, drop_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_protocol_err();
    test_reset_midop();
`ifdef RL_GATE_DROP_FWD_EN
    test_drop_fwd();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rl_ingress_gate.md
Name: rl_ingress_gate

Overview:
Ingress stage directly upstream of the per-client token bucket rate limiter. It buffers incoming packet descriptors in a FIFO and issues one client ID per cycle to the limiter. It pairs the limiter's registered accept/drop verdict (returned one cycle after issue) with the buffered descriptor. Accepted descriptors are forwarded downstream over a valid/ready interface; dropped descriptors are discarded and counted.

Parameters:
CLIENT_W, 10, client ID width; must equal the limiter's client width
DESC_W, 32, opaque descriptor payload width
FIFO_DEPTH, 16, input FIFO entries; power of two, minimum 2
CNT_W, 32, width of the accept and drop statistics counters

Ports:
clk  input  1  single system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream descriptor valid
in_ready  output  1  FIFO not full
in_client_id  input  CLIENT_W  client of the incoming descriptor
in_desc  input  DESC_W  descriptor payload
lim_pkt_valid  output  1  issue strobe to the limiter, one cycle per descriptor
lim_client_id  output  CLIENT_W  FIFO-head client ID
lim_accept  input  1  limiter verdict: accept, valid in the cycle after issue
lim_drop  input  1  limiter verdict: drop, valid in the cycle after issue
out_valid  output  1  output buffer head valid
out_ready  input  1  downstream ready
out_client_id  output  CLIENT_W  head client ID
out_desc  output  DESC_W  head descriptor
out_dropped  output  1  head was dropped by the limiter (optional feature only)
accept_cnt  output  CNT_W  saturating count of accepted descriptors
drop_cnt  output  CNT_W  saturating count of dropped descriptors
err_protocol  output  1  sticky error: a verdict was malformed
fifo_level  output  $clog2(FIFO_DEPTH)+1  current input FIFO occupancy

Behaviour:
- Reset values: in_ready=0 while rst_n is low, then 1 (FIFO empty). lim_pkt_valid, out_valid, out_dropped and err_protocol are 0. accept_cnt, drop_cnt and fifo_level are 0.
- Reset mid-operation discards all FIFO, in-flight and output entries. Verdicts arriving after reset release are ignored, because no descriptor is in flight.
- Input FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full, registered with no same-cycle pass-through, so a full FIFO blocks even if a pop occurs that cycle.
  - A descriptor written at cycle N is eligible for issue at N+1.
- Output buffer: 2 entries, FIFO-ordered. Pop when out_valid && out_ready. out_* are driven from the head entry.
- Issue:
  - Define occ_eff = out_occ - pop + inflight, where inflight = lim_pkt_valid in the previous cycle.
  - Issue at cycle N when the FIFO is non-empty and occ_eff < 2.
  - On issue, lim_pkt_valid=1 and lim_client_id=head client ID for exactly one cycle. The head is popped into the single in-flight register.
  - When idle, lim_client_id shows the FIFO head (0 if empty); the limiter ignores it.
- Verdict cycle (N+1), sampled only when inflight=1:
  - lim_accept=1, lim_drop=0: write the in-flight entry to the output buffer, visible as out_valid at N+2; increment accept_cnt.
  - lim_drop=1, lim_accept=0: discard the entry; increment drop_cnt.
  - Both or neither set: treat as drop, increment drop_cnt, set err_protocol. err_protocol clears only on reset.
- Throughput: one descriptor per cycle with out_ready held high. Minimum latency is 3 cycles from in push to out_valid.
- Ordering: output order equals input order among accepted descriptors.
- Counters saturate at all-ones and never wrap. Accept and drop are mutually exclusive per cycle.
- A verdict with inflight=0 is ignored.

Optional Feature:
RL_GATE_DROP_FWD_EN
- Defined: dropped descriptors are written to the output buffer with out_dropped=1, sharing issue credit rules with accepts. drop_cnt still increments. Malformed verdicts are forwarded with out_dropped=1.
- Undefined: drops are discarded and out_dropped is tied to 0.

Test Plan:
- Reset, then push client 5 with desc 0xA5A5_0001; limiter accepts -> lim_pkt_valid at cycle 1 with client 5; out_valid at cycle 3 with 0xA5A5_0001; accept_cnt=1.
- Stream 8 descriptors back-to-back with out_ready=1 and limiter alternating accept/drop -> 4 outputs in order, accept_cnt=4, drop_cnt=4, lim_pkt_valid high for 8 consecutive cycles.
- Hold out_ready=0 and push 20 descriptors, all accepted -> 2 in output buffer, fifo_level=16, in_ready=0, issue stalls. Release out_ready -> all 18 remaining delivered in order.
- Verdict with lim_accept=1 and lim_drop=1 -> descriptor dropped, drop_cnt+1, err_protocol=1 and stays set until rst_n low.
- Assert rst_n low with 3 entries queued and 1 in flight -> all outputs 0 immediately. After release, a stray lim_accept is ignored and accept_cnt stays 0.
- With RL_GATE_DROP_FWD_EN defined, a drop verdict for client 7 -> out_valid with out_dropped=1 and out_client_id=7; drop_cnt=1.
